// File: rtl/fp_div.sv
// Iterative single-precision divider: restoring radix-2 mantissa division,
// one quotient bit per clock, five rounding modes, early exit on specials.
module fp_div #(
    parameter int W = 32,
    parameter int M = 22,
    parameter int E = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         act,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [2:0]   round_m,
    output logic [W-1:0] out,
    output logic         done,
    output logic         busy,
    output logic         ov,
    output logic         un,
    output logic         inv,
    output logic         inexact,
    output logic         dz
);
    localparam int EW = E - M;
    localparam int XW = EW + 2;
    localparam int NQ = M + 3;
    localparam int CW = $clog2(NQ);
    localparam logic [CW-1:0] LAST = CW'(NQ - 1);

    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] ZERO = '0;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RZ  = 3'd1;
    localparam logic [2:0] RD  = 3'd2;
    localparam logic [2:0] RU  = 3'd3;
    localparam logic [2:0] RNA = 3'd4;

    localparam logic [W-2:0] INF  = {{EW{1'b1}}, {(M+1){1'b0}}};
    localparam logic [W-2:0] MAXF = {{(EW-1){1'b1}}, 1'b0, {(M+1){1'b1}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {M{1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, DIV, ROUND} state_t;

    state_t state_q, state_d;

    logic [W-1:0]          a_q, b_q;
    logic [2:0]            rm_q;
    logic signed [XW-1:0]  eq_q;
    logic [M+2:0]          r_q;
    logic [M+1:0]          qt_q;
    logic [CW-1:0]         cnt_q;

    logic [EW-1:0] ea, eb;
    logic [M:0]    fa, fb;
    logic          sgn;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;

    assign ea  = a_q[E:M+1];
    assign eb  = b_q[E:M+1];
    assign fa  = a_q[M:0];
    assign fb  = b_q[M:0];
    assign sgn = a_q[W-1] ^ b_q[W-1];

    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (fa == '0);
    assign b_inf   = (eb == '1) && (fb == '0);
    assign a_nan   = (ea == '1) && (fa != '0);
    assign b_nan   = (eb == '1) && (fb != '0);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    logic [W-1:0] sp_res;
    logic         sp_inv, sp_dz;

    always_comb begin
        sp_res = {sgn, INF};
        sp_inv = 1'b0;
        sp_dz  = 1'b0;
        if (a_nan | b_nan) begin
            sp_res = QNAN;
            sp_inv = (a_nan & ~fa[M]) | (b_nan & ~fb[M]);
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (b_zero) begin
            sp_dz  = ~a_inf;
        end else if (a_zero | b_inf) begin
            sp_res = {sgn, {(W-1){1'b0}}};
        end
    end

    logic [M+1:0]         ma, mb, rdiff;
    logic signed [XW-1:0] eq0;
    logic                 lt, qbit;

    assign ma    = {1'b1, fa};
    assign mb    = {1'b1, fb};
    assign lt    = (ma < mb);
    assign eq0   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
    assign qbit  = (r_q >= {1'b0, mb});
    // remainder after subtraction is always below mb, so 24 bits suffice
    assign rdiff = r_q[M+1:0] - (qbit ? mb : '0);

    logic [M:0]           f, f_r;
    logic                 g, s, up, to_inf, ovf, unf;
    logic [XW+M:0]        sum;
    logic signed [XW-1:0] eq_r;
    logic [W-1:0]         res;

    assign f = qt_q[M+1:1];
    assign g = qt_q[0];
    assign s = (r_q != '0);

    always_comb begin
        up     = 1'b0;
        to_inf = 1'b0;
        unique case (rm_q)
            RNE: begin up = g & (s | f[0]); to_inf = 1'b1; end
            RNA: begin up = g;              to_inf = 1'b1; end
            RU:  begin up = (g | s) & ~sgn; to_inf = ~sgn; end
            RD:  begin up = (g | s) & sgn;  to_inf = sgn;  end
            default: ;
        endcase
    end

    assign sum  = {eq_q, f} + {{(XW+M){1'b0}}, up};
    assign eq_r = sum[XW+M:M+1];
    assign f_r  = sum[M:0];
    assign ovf  = (eq_r >= EMAX);
    assign unf  = ~ovf & (eq_r <= ZERO);

    always_comb begin
        res = {sgn, eq_r[EW-1:0], f_r};
        if (ovf)
            res = {sgn, to_inf ? INF : MAXF};
        else if (unf)
            res = {sgn, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (act) state_d = PREP;
            PREP:  state_d = special ? IDLE : DIV;
            DIV:   if (cnt_q == LAST) state_d = ROUND;
            ROUND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            eq_q    <= '0;
            r_q     <= '0;
            qt_q    <= '0;
            cnt_q   <= '0;
            out     <= '0;
            done    <= 1'b0;
            ov      <= 1'b0;
            un      <= 1'b0;
            inv     <= 1'b0;
            inexact <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: if (act) begin
                    a_q  <= in1;
                    b_q  <= in2;
                    rm_q <= round_m;
                end
                PREP: if (special) begin
                    out     <= sp_res;
                    ov      <= 1'b0;
                    un      <= 1'b0;
                    inv     <= sp_inv;
                    inexact <= 1'b0;
                    dz      <= sp_dz;
                    done    <= 1'b1;
                end else begin
                    r_q   <= lt ? {ma, 1'b0} : {1'b0, ma};
                    eq_q  <= lt ? eq0 - ONE : eq0;
                    qt_q  <= '0;
                    cnt_q <= '0;
                end
                DIV: begin
                    r_q   <= {rdiff, 1'b0};
                    qt_q  <= {qt_q[M:0], qbit};
                    cnt_q <= cnt_q + CW'(1);
                end
                ROUND: begin
                    out     <= res;
                    ov      <= ovf;
                    un      <= unf;
                    inv     <= 1'b0;
                    dz      <= 1'b0;
                    inexact <= g | s | ovf | unf;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
